// File: rtl/fifo2gmii24_if.sv
// FIFO-side and GMII-side signal bundle for the fifo2gmii24 framer.
// master: framer side (pops FIFO, drives GMII); slave: FIFO/PHY peer side.
interface fifo2gmii24_if;
  logic        tx_go;
  logic [28:0] fifo_dout;
  logic [10:0] fifo_cnt;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  txd;
  logic        tx_en;
  logic        underflow;

  modport master (
    input  tx_go, fifo_dout, fifo_cnt, fifo_empty,
    output fifo_rd_en, txd, tx_en, underflow
  );

  modport slave (
    output tx_go, fifo_dout, fifo_cnt, fifo_empty,
    input  fifo_rd_en, txd, tx_en, underflow
  );
endinterface

// File: rtl/fifo2gmii24.sv
// Line framer: show-ahead FIFO words -> Ethernet/IPv4/UDP frame on GMII TX.
// Ports: clk125, sys_rst_n, bus (fifo2gmii24_if.master). Option: FIFO2GMII_IPCSUM_EN.
module fifo2gmii24 #(
  parameter logic [47:0] SRC_MAC  = 48'h00_37_FF_00_00_01,
  parameter logic [47:0] DST_MAC  = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [31:0] IPV4_SRC = {8'd192, 8'd168, 8'd0, 8'd2},
  parameter logic [31:0] IPV4_DST = {8'd192, 8'd168, 8'd0, 8'd1},
  parameter logic [15:0] SRC_PORT = 16'd12345,
  parameter logic [15:0] DST_PORT = 16'd12345,
  parameter logic [10:0] PIXELS   = 11'd640,
  parameter logic [7:0]  IFG      = 8'd12
) (
  input logic         clk125,
  input logic         sys_rst_n,
  fifo2gmii24_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, PRE, HDR, INFO, PAY, FCS, GAP
  } state_t;

  localparam logic [15:0] TOT_LEN =
    16'd30 + {4'd0, PIXELS, 1'b0};
  localparam logic [15:0] UDP_LEN =
    16'd10 + {4'd0, PIXELS, 1'b0};
  localparam logic [11:0] PAY_LAST =
    {PIXELS, 1'b0} - 12'd1;
  // GAP plus the IDLE decision cycle give IFG idle cycles
  localparam logic [11:0] GAP_LAST =
    {4'd0, IFG} - 12'd2;

  state_t      state;
  logic [11:0] cnt;
  logic [15:0] ident;
  logic [15:0] csum;
  logic [31:0] crc;
  logic        uf_slot;
  logic [7:0]  txd_r;
  logic        tx_en_r;
  logic        uf_r;
  logic [7:0]  nb;
  logic [335:0] hdr;
  logic [335:0] hdr_sh;
  logic [31:0] fcs;
  logic [28:0] d;
  logic        go;
  logic        unused;

  assign d      = bus.fifo_dout;
  assign unused = d[28];
  assign go     = bus.tx_go &&
                  (bus.fifo_cnt >= PIXELS);

  assign hdr = {
    DST_MAC, SRC_MAC, 16'h0800,
    8'h45, 8'h00, TOT_LEN, ident,
    16'h4000, 8'h40, 8'h11, csum,
    IPV4_SRC, IPV4_DST,
    SRC_PORT, DST_PORT, UDP_LEN, 16'h0000
  };
  assign hdr_sh = hdr << {cnt[5:0], 3'b000};
  assign fcs    = ~crc;

  function automatic logic [31:0] crc8(
    input logic [31:0] c,
    input logic [7:0]  b
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

`ifdef FIFO2GMII_IPCSUM_EN
  logic [19:0] sum;
  logic [16:0] f1;
  logic [15:0] f2;

  always_comb begin
    sum = 20'h4500 + {4'd0, TOT_LEN} +
          {4'd0, ident} + 20'h4000 +
          20'h4011 +
          {4'd0, IPV4_SRC[31:16]} +
          {4'd0, IPV4_SRC[15:0]} +
          {4'd0, IPV4_DST[31:16]} +
          {4'd0, IPV4_DST[15:0]};
    f1 = {1'b0, sum[15:0]} + {13'd0, sum[19:16]};
    f2 = f1[15:0] + {15'd0, f1[16]};
  end

  // ident is stable through PRE; ready well before offset 0x18
  always_ff @(posedge clk125) begin
    if (!sys_rst_n)      csum <= 16'h0000;
    else if (state == PRE) csum <= ~f2;
  end
`else
  assign csum = 16'h0000;
`endif

  always_comb begin
    nb = 8'h00;
    unique case (state)
      PRE:  nb = (cnt == 12'd7) ? 8'hD5 : 8'h55;
      HDR:  nb = hdr_sh[335:328];
      INFO: nb = cnt[0] ?
                 {3'b000, d[27], 1'b0, d[26:24]} :
                 d[23:16];
      PAY: begin
        if (!cnt[0])
          nb = bus.fifo_empty ? 8'h00 : d[15:8];
        else
          nb = uf_slot ? 8'h00 : d[7:0];
      end
      FCS:  nb = fcs[{cnt[1:0], 3'b000} +: 8];
      default: nb = 8'h00;
    endcase
  end

  // Pop while the low byte is being taken so the next
  // high byte already sees the new head word.
  assign bus.fifo_rd_en = (state == PAY) && cnt[0] &&
                          !uf_slot && !bus.fifo_empty;
  assign bus.txd       = txd_r;
  assign bus.tx_en     = tx_en_r;
  assign bus.underflow = uf_r;

  always_ff @(posedge clk125) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      cnt     <= 12'd0;
      ident   <= 16'h0000;
      crc     <= 32'hFFFFFFFF;
      uf_slot <= 1'b0;
      txd_r   <= 8'h00;
      tx_en_r <= 1'b0;
      uf_r    <= 1'b0;
    end else begin
      txd_r   <= nb;
      tx_en_r <= 1'b0;
      uf_r    <= 1'b0;
      unique case (state)
        IDLE: begin
          crc <= 32'hFFFFFFFF;
          cnt <= 12'd0;
          if (go) state <= PRE;
        end
        PRE: begin
          tx_en_r <= 1'b1;
          cnt     <= cnt + 12'd1;
          if (cnt == 12'd7) begin
            state <= HDR;
            cnt   <= 12'd0;
          end
        end
        HDR: begin
          tx_en_r <= 1'b1;
          crc     <= crc8(crc, nb);
          cnt     <= cnt + 12'd1;
          if (cnt == 12'd41) begin
            state <= INFO;
            cnt   <= 12'd0;
          end
        end
        INFO: begin
          tx_en_r <= 1'b1;
          crc     <= crc8(crc, nb);
          cnt     <= cnt + 12'd1;
          if (cnt == 12'd1) begin
            state <= PAY;
            cnt   <= 12'd0;
          end
        end
        PAY: begin
          tx_en_r <= 1'b1;
          crc     <= crc8(crc, nb);
          cnt     <= cnt + 12'd1;
          if (!cnt[0]) begin
            uf_slot <= bus.fifo_empty;
            uf_r    <= bus.fifo_empty;
          end
          if (cnt == PAY_LAST) begin
            state <= FCS;
            cnt   <= 12'd0;
          end
        end
        FCS: begin
          tx_en_r <= 1'b1;
          cnt     <= cnt + 12'd1;
          if (cnt == 12'd3) begin
            state <= GAP;
            cnt   <= 12'd0;
            ident <= ident + 16'd1;
          end
        end
        GAP: begin
          cnt <= cnt + 12'd1;
          if (cnt == GAP_LAST) begin
            state <= IDLE;
            cnt   <= 12'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo2gmii24.sv
// Bench for fifo2gmii24: FIFO model, frame capture, byte-level reference.
// Checks framing, lengths, ident, checksum, CRC, underflow, reset abort.
module tb_fifo2gmii24;

  localparam int P = 640;
  localparam int FLEN = 8 + 44 + 2 * P + 4;

  typedef logic [7:0] bq_t [$];

  logic clk = 1'b0;
  logic sys_rst_n;
  logic force_e;

  fifo2gmii24_if bus ();

  fifo2gmii24 dut (
    .clk125   (clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  always #4 clk = ~clk;

  logic [28:0] mem [0:4095];
  int wr_ptr;
  int rd_ptr;

  assign bus.fifo_dout  = mem[rd_ptr % 4096];
  assign bus.fifo_cnt   = 11'(wr_ptr - rd_ptr);
  assign bus.fifo_empty = (wr_ptr == rd_ptr) || force_e;

  always @(posedge clk)
    if (bus.fifo_rd_en && (wr_ptr != rd_ptr))
      rd_ptr <= rd_ptr + 1;

  int checks;
  int failures;
  logic [28:0] model [$];
  int mh;
  logic [15:0] epix [$];
  logic [15:0] exp_cs;
  bq_t cap;
  bq_t ex;
  int n_rd, n_uf, alt_bad, gap, t_wait, post_rst;

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, o, e);
    end
  endtask

  task automatic push(input logic [28:0] w);
    mem[wr_ptr % 4096] = w;
    wr_ptr++;
    model.push_back(w);
  endtask

  task automatic push_rand(input int n);
    logic [28:0] w;
    for (int i = 0; i < n; i++) begin
      w = {1'b0, 1'($urandom), 11'($urandom),
           16'($urandom)};
      push(w);
    end
  endtask

  task automatic build(input logic [28:0] head,
                       input logic [15:0] id,
                       output bq_t f);
    logic [15:0] hw [21];
    logic [31:0] s;
    logic [31:0] c;
    bq_t h;
    f = {};
    h = {};
    for (int i = 0; i < 7; i++) f.push_back(8'h55);
    f.push_back(8'hD5);
    hw = '{16'hFFFF, 16'hFFFF, 16'hFFFF,
           16'h0037, 16'hFF00, 16'h0001,
           16'h0800, 16'h4500, 16'(30 + 2 * P), id,
           16'h4000, 16'h4011, 16'h0000,
           16'hC0A8, 16'h0002, 16'hC0A8, 16'h0001,
           16'd12345, 16'd12345, 16'(10 + 2 * P),
           16'h0000};
    s = 0;
    for (int i = 7; i <= 16; i++) s += {16'd0, hw[i]};
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    exp_cs = ~s[15:0];
`ifdef FIFO2GMII_IPCSUM_EN
    hw[12] = exp_cs;
`endif
    for (int i = 0; i < 21; i++) begin
      h.push_back(hw[i][15:8]);
      h.push_back(hw[i][7:0]);
    end
    h.push_back(head[23:16]);
    h.push_back({3'b000, head[27], 1'b0, head[26:24]});
    foreach (epix[i]) begin
      h.push_back(epix[i][15:8]);
      h.push_back(epix[i][7:0]);
    end
    c = 32'hFFFFFFFF;
    foreach (h[i])
      for (int b = 0; b < 8; b++)
        c = (c[0] ^ h[i][b]) ? ((c >> 1) ^ 32'hEDB88320)
                             : (c >> 1);
    c = ~c;
    for (int b = 0; b < 4; b++) h.push_back(c[8*b +: 8]);
    foreach (h[i]) f.push_back(h[i]);
  endtask

  task automatic capture(input bit here,
                         input int force_after,
                         input int rst_after,
                         input bit meas);
    int force_at;
    bit rst_done;
    bit prev_rd;
    cap = {};
    n_rd = 0; n_uf = 0; alt_bad = 0; gap = 0;
    t_wait = 0; post_rst = 0;
    force_at = -1; rst_done = 0; prev_rd = 0;
    if (!here) @(negedge clk);
    while (!bus.tx_en && t_wait < 5000) begin
      @(negedge clk);
      t_wait++;
    end
    while (bus.tx_en && cap.size() < 3000) begin
      if (force_at >= 0 && cap.size() == force_at)
        force_e = 1'b1;
      if (force_at >= 0 && cap.size() == force_at + 20)
        force_e = 1'b0;
      if (rst_done) post_rst++;
      cap.push_back(bus.txd);
      if (bus.underflow) n_uf++;
      if (bus.fifo_rd_en) begin
        if (prev_rd) alt_bad++;
        n_rd++;
        if (n_rd == force_after && force_at < 0)
          force_at = cap.size();
        if (n_rd == rst_after && !rst_done) begin
          sys_rst_n = 1'b0;
          rst_done  = 1'b1;
        end
      end
      prev_rd = bus.fifo_rd_en;
      @(negedge clk);
    end
    force_e = 1'b0;
    if (meas)
      while (!bus.tx_en && gap < 200) begin
        gap++;
        @(negedge clk);
      end
  endtask

  task automatic cmp_frame(input string tag);
    int bad;
    bad = 0;
    chk({tag, "_start"}, 32'(t_wait < 5000), 1);
    chk({tag, "_len"}, cap.size(), ex.size());
    foreach (ex[i])
      if (i >= cap.size() || cap[i] !== ex[i]) bad++;
    chk({tag, "_bytes_bad"}, bad, 0);
  endtask

  initial begin
    int bad;
    int start;
    checks = 0; failures = 0;
    wr_ptr = 0; rd_ptr = 0; mh = 0;
    force_e = 1'b0;
    sys_rst_n = 1'b0;
    bus.tx_go = 1'b1;
    for (int i = 0; i < P; i++)
      push({1'b0, 1'b1, 11'h123, 16'(i)});

    repeat (5) begin
      @(negedge clk);
      chk("reset_out",
          {bus.txd, bus.tx_en, bus.fifo_rd_en, bus.underflow},
          0);
    end
    sys_rst_n = 1'b1;

    capture(0, -1, -1, 0);
    chk("release_latency", t_wait, 1);
    epix = {};
    for (int i = 0; i < P; i++) epix.push_back(model[mh + i][15:0]);
    build(model[mh], 16'h0000, ex);
    mh += P;
    cmp_frame("single");
    bad = 0;
    for (int i = 0; i < 7; i++) if (cap[i] !== 8'h55) bad++;
    if (cap[7] !== 8'hD5) bad++;
    chk("preamble_bad", bad, 0);
    chk("tot_len", {cap[8+16], cap[8+17]}, 16'h051E);
    chk("udp_len", {cap[8+38], cap[8+39]}, 16'h050A);
    chk("info_2a", cap[8+42], 8'h23);
    chk("info_2b", cap[8+43], 8'h11);
    chk("ident0", {cap[8+18], cap[8+19]}, 16'h0000);
`ifdef FIFO2GMII_IPCSUM_EN
    chk("ip_csum", {cap[8+24], cap[8+25]}, exp_cs);
`else
    chk("ip_csum", {cap[8+24], cap[8+25]}, 16'h0000);
`endif
    chk("pay_first", {cap[52], cap[53], cap[54], cap[55]},
        32'h00000001);
    chk("pay_last", {cap[FLEN-6], cap[FLEN-5]}, 16'h027F);
    chk("fcs", {cap[FLEN-4], cap[FLEN-3], cap[FLEN-2],
                cap[FLEN-1]},
        {ex[FLEN-4], ex[FLEN-3], ex[FLEN-2], ex[FLEN-1]});
    chk("tx_en_len", cap.size(), FLEN);
    chk("rd_pulses", n_rd, P);
    chk("rd_alt", alt_bad, 0);
    chk("uf_none", n_uf, 0);

    sys_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    push_rand(2 * P);
    sys_rst_n = 1'b1;
    capture(0, -1, -1, 1);
    epix = {};
    for (int i = 0; i < P; i++) epix.push_back(model[mh + i][15:0]);
    build(model[mh], 16'h0000, ex);
    mh += P;
    cmp_frame("b2b_a");
    chk("b2b_a_ident", {cap[8+18], cap[8+19]}, 16'h0000);
    chk("b2b_gap", gap, 12);
    capture(1, -1, -1, 0);
    epix = {};
    for (int i = 0; i < P; i++) epix.push_back(model[mh + i][15:0]);
    build(model[mh], 16'h0001, ex);
    mh += P;
    cmp_frame("b2b_b");
    chk("b2b_b_ident", {cap[8+18], cap[8+19]}, 16'h0001);
    chk("b2b_b_rd", n_rd, P);

    push_rand(P);
    capture(0, 300, -1, 0);
    epix = {};
    for (int i = 0; i < 300; i++) epix.push_back(model[mh + i][15:0]);
    for (int i = 0; i < 10; i++) epix.push_back(16'h0000);
    for (int i = 300; i < P - 10; i++)
      epix.push_back(model[mh + i][15:0]);
    build(model[mh], 16'h0002, ex);
    mh += P - 10;
    cmp_frame("uflow");
    chk("uflow_pulses", n_uf, 10);
    chk("uflow_pops", n_rd, P - 10);
    chk("uflow_len", cap.size(), FLEN);

    push_rand(P - 10);
    start = rd_ptr;
    capture(0, -1, 100, 0);
    chk("abort_txen_low", post_rst, 0);
    chk("abort_short", 32'(cap.size() < FLEN), 1);
    chk("abort_pops", n_rd, 100);
    chk("abort_fifo_pops", rd_ptr - start, 100);
    mh += 100;
    repeat (3) @(negedge clk);
    push_rand(100);
    sys_rst_n = 1'b1;
    capture(0, -1, -1, 0);
    epix = {};
    for (int i = 0; i < P; i++) epix.push_back(model[mh + i][15:0]);
    build(model[mh], 16'h0000, ex);
    mh += P;
    cmp_frame("after_abort");
    chk("after_abort_ident", {cap[8+18], cap[8+19]}, 16'h0000);
    chk("after_abort_pre", {cap[0], cap[6], cap[7]}, 24'h5555D5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
